uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Transmit-side buffer between the interface circuit and `uart_tx`. Accepts result bytes from the interface on a single-cycle write strobe and stores them in a 2^FIFO_W-deep FIFO. Drives `uart_tx` one byte at a time with a `tx_start` pulse, waits for `tx_done_tick` before issuing the next byte, and exposes full/empty/count status.

## Interface
- `DBIT`, 8, data bits per word.
- `FIFO_W`, 2, FIFO address bits; depth = 2^FIFO_W.
- `i_clk`  in  1  system clock; all state changes on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_wr`  in  1  write strobe from interface circuit; one byte per high cycle.
- `i_wdata`  in  DBIT  byte to enqueue, sampled when `i_wr`=1.
- `tx_done_tick`  in  1  one-cycle pulse from `uart_tx` at end of stop bit.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `o_din`  out  DBIT  byte presented to `uart_tx` `din`; stable from `tx_start` until next load.
- `o_full`  out  1  FIFO holds 2^FIFO_W entries.
- `o_empty`  out  1  FIFO holds 0 entries.
- `o_count`  out  FIFO_W+1  current occupancy, 0..2^FIFO_W.
- `o_busy`  out  1  FSM not in IDLE (byte in flight).
- `o_overflow`  out  1  sticky dropped-write flag (see Configuration).

## Operation
- Storage: 2^FIFO_W x DBIT register array.
- Pointers: `wr_ptr` and `rd_ptr`, FIFO_W+1 bits each, free-running with natural wrap.
  - Empty when the pointers are equal.
  - Full when the low FIFO_W bits are equal and the MSBs differ.
  - `o_count` = `wr_ptr` − `rd_ptr`, modulo 2^(FIFO_W+1).
- Write accept: `i_wr`=1 and `o_full`=0. Stores `i_wdata` at `wr_ptr` and increments `wr_ptr`.
- Write while full: the byte is dropped and FIFO contents are unchanged. This holds even if a pop happens in the same cycle.
- Simultaneous accepted write and pop: both take effect and `o_count` is unchanged.
- FSM states: IDLE, WAIT.
  - IDLE, `o_empty`=0 at the edge:
    - `o_din` <= mem[`rd_ptr`]
    - `rd_ptr`++
    - `tx_start` <= 1
    - go to WAIT
  - IDLE, `o_empty`=1: stay in IDLE; `tx_start` <= 0.
  - WAIT: `tx_start` <= 0. On `tx_done_tick`=1, go to IDLE; otherwise stay in WAIT.
  - A `tx_done_tick` received in IDLE is ignored.
- Bytes leave in write order; no reordering or duplication.
- Reset values:
  - state IDLE; pointers 0.
  - `o_empty`=1, `o_full`=0, `o_count`=0.
  - `tx_start`=0, `o_din`=0, `o_busy`=0, `o_overflow`=0.
- Reset mid-transfer: the FSM returns to IDLE and all queued data is discarded. A later `tx_done_tick` from `uart_tx` lands in IDLE and is ignored.

## Timing
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.
- `o_empty`, `o_full` and `o_count` reflect a write accepted at edge k in the cycle after edge k.
- First-byte latency: write accepted at edge k into an empty, idle buffer → `tx_start` high for exactly the cycle after edge k+1, with `o_din` valid in that same cycle.
- `tx_start` is never high for more than one consecutive cycle.
- Back-to-back bytes: `tx_done_tick` sampled at edge m → IDLE. If the FIFO is non-empty, the next `tx_start` follows edge m+1.
- `o_busy` is high from the `tx_start` cycle through the cycle in which `tx_done_tick` is sampled.

## Configuration
- Macro: `UART_TX_BUF_OVERFLOW_EN`.
- Defined:
  - `o_overflow` sets on any cycle with `i_wr`=1 and `o_full`=1.
  - It stays set until `i_reset`.
- Undefined:
  - `o_overflow` is tied to 0.
  - Writes while full are still dropped silently.
  - No flag logic is synthesized.

## Test plan
- Reset: assert `i_reset` 2 cycles → `o_empty`=1, `o_full`=0, `o_count`=0, `tx_start`=0, `o_din`=0x00, `o_busy`=0, `o_overflow`=0.
- Single byte: write 0xA5 at edge k into an idle buffer → `tx_start` pulses once after edge k+1 with `o_din`=0xA5. `o_busy` stays 1 until `tx_done_tick`, then returns to 0.
- Fill and overflow (DBIT=8, FIFO_W=2):
  - Write 0x10 and let it go in flight, holding `tx_done_tick` low.
  - Write 0x11, 0x12, 0x13, 0x14 → `o_full`=1, `o_count`=4.
  - Write 0x55 → dropped; `o_overflow`=1 only when the macro is defined.
  - Release done ticks → output order is 0x10, 0x11, 0x12, 0x13, 0x14.
- Simultaneous write and pop: with `o_count`=2 and the FSM in IDLE, write 0x77 on the pop edge → `o_count` stays 2. 0x77 is sent last.
- Reset mid-transfer: reset during WAIT with 3 bytes queued, then pulse `tx_done_tick` → no `tx_start`, `o_empty`=1, `o_busy`=0.
- Wrap-around: stream 10 bytes 0x00..0x09 with `tx_done_tick` 20 cycles after each `tx_start` → all 10 bytes are sent in order and the pointers wrap at least twice.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
// Transmit-side buffer between the interface circuit and uart_tx. Bytes are
// written on a one-cycle strobe into a 2^FIFO_W-deep FIFO and handed to
// uart_tx one at a time: a tx_start pulse launches a byte and the next byte
// is only issued after uart_tx reports tx_done_tick.
//
// Optional feature macro: UART_TX_BUF_OVERFLOW_EN
//   defined   -> o_overflow is a sticky flag set by any write while full
//   undefined -> o_overflow is tied to 0 (writes while full still dropped)
//
// Ports
//   i_clk         in   system clock, rising edge
//   i_reset       in   synchronous active-high reset
//   i_wr          in   write strobe, one byte per high cycle
//   i_wdata       in   DBIT  byte to enqueue
//   tx_done_tick  in   end-of-stop-bit pulse from uart_tx
//   tx_start      out  one-cycle start pulse to uart_tx
//   o_din         out  DBIT  byte presented to uart_tx din
//   o_full        out  FIFO holds 2^FIFO_W entries
//   o_empty       out  FIFO holds 0 entries
//   o_count       out  FIFO_W+1  current occupancy
//   o_busy        out  byte in flight (FSM in WAIT)
//   o_overflow    out  sticky dropped-write flag
// ---------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [DBIT-1:0]   i_wdata,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   o_din,
  output logic              o_full,
  output logic              o_empty,
  output logic [FIFO_W:0]   o_count,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int              DEPTH   = 1 << FIFO_W;
  localparam logic [FIFO_W:0] PTR_ONE = {{FIFO_W{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [FIFO_W:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_W:0]   rd_ptr_q, rd_ptr_d;
  logic              tx_start_q, tx_start_d;
  logic [DBIT-1:0]   din_q, din_d;
  logic [DBIT-1:0]   mem [DEPTH];
  logic              wr_en;

  // Status decoded from the free-running pointers; the extra MSB separates
  // full from empty when the low address bits match.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[FIFO_W-1:0] == rd_ptr_q[FIFO_W-1:0]) &&
                   (wr_ptr_q[FIFO_W] != rd_ptr_q[FIFO_W]);
  assign o_count = wr_ptr_q - rd_ptr_q;

  // A write is refused whenever the FIFO is full at the edge, even if a pop
  // frees a slot in that same cycle.
  assign wr_en = i_wr & ~o_full;

  assign tx_start = tx_start_q;
  assign o_din    = din_q;
  assign o_busy   = (state_q == WAIT);

  // Next-state logic for pointers and the transmit FSM.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    din_d      = din_q;
    tx_start_d = 1'b0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (!o_empty) begin
          din_d      = mem[rd_ptr_q[FIFO_W-1:0]];
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          tx_start_d = 1'b1;
          state_d    = WAIT;
        end else begin
          state_d    = IDLE;
        end
      end
      WAIT: begin
        if (tx_done_tick) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_start_q <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_start_q <= tx_start_d;
      din_q      <= din_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset) begin
      mem[wr_ptr_q[FIFO_W-1:0]] <= i_wdata;
    end
  end

`ifdef UART_TX_BUF_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Sticky flag: any write attempt while full sets it until reset.
  always_comb begin
    overflow_d = overflow_q | (i_wr & o_full);
  end

  // Overflow flag register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffer
// Self-checking bench for uart_tx_buffer (DBIT=8, FIFO_W=2). A queue-based
// reference model tracks FIFO contents, the in-flight byte and the overflow
// flag; every cycle all outputs are compared against it. Directed scenarios
// are followed by a randomized traffic phase.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffer;

  localparam int DBIT   = 8;
  localparam int FIFO_W = 2;
  localparam int DEPTH  = 4;

  logic            clk;
  logic            i_reset;
  logic            i_wr;
  logic [DBIT-1:0] i_wdata;
  logic            tx_done_tick;
  logic            tx_start;
  logic [DBIT-1:0] o_din;
  logic            o_full;
  logic            o_empty;
  logic [FIFO_W:0] o_count;
  logic            o_busy;
  logic            o_overflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mq[$];
  bit         m_busy  = 1'b0;
  bit         m_start = 1'b0;
  logic [7:0] m_din   = 8'h00;
  bit         m_ovf   = 1'b0;

  // bytes observed leaving the DUT
  logic [7:0] dut_log[$];

  uart_tx_buffer #(.DBIT(DBIT), .FIFO_W(FIFO_W)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_wr         (i_wr),
    .i_wdata      (i_wdata),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .o_din        (o_din),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_count      (o_count),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge using pre-edge inputs.
  task automatic model_edge(input logic wr, input logic [7:0] d, input logic done, input logic rst);
    bit was_full;
    if (rst) begin
      mq.delete();
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_din   = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
`ifdef UART_TX_BUF_OVERFLOW_EN
      if (wr && was_full) m_ovf = 1'b1;
`endif
      if (!m_busy) begin
        if (mq.size() != 0) begin
          m_din   = mq.pop_front();
          m_start = 1'b1;
          m_busy  = 1'b1;
        end else begin
          m_start = 1'b0;
        end
      end else begin
        m_start = 1'b0;
        if (done) m_busy = 1'b0;
      end
      if (wr && !was_full) mq.push_back(d);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    chk("count",    32'(o_count),    32'(sz));
    chk("empty",    32'(o_empty),    32'(sz == 0));
    chk("full",     32'(o_full),     32'(sz == DEPTH));
    chk("busy",     32'(o_busy),     32'(m_busy));
    chk("tx_start", 32'(tx_start),   32'(m_start));
    chk("din",      32'(o_din),      32'(m_din));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
  endtask

  // One clock cycle: drive inputs, step the model at the edge, check #1 later.
  task automatic step(input logic wr, input logic [7:0] d, input logic done);
    i_wr         = wr;
    i_wdata      = d;
    tx_done_tick = done;
    @(posedge clk);
    model_edge(wr, d, done, i_reset);
    #1;
    check_outputs();
    if (tx_start === 1'b1) dut_log.push_back(o_din);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] fill_exp[5];
    int nxt;
    int cd;
    int guard;
    logic wr;
    logic dn;

    fill_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    i_reset = 1'b1;
    i_wr = 1'b0;
    i_wdata = 8'h00;
    tx_done_tick = 1'b0;
    #2;

    // reset held for two cycles
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    i_reset = 1'b0;
    idle(2);

    // single byte: write A5, observe start, hold, then finish
    dut_log.delete();
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    idle(5);
    step(1'b0, 8'h00, 1'b1);
    idle(3);
    chk("single_n",    32'(dut_log.size()), 32'd1);
    if (dut_log.size() > 0) chk("single_byte", 32'(dut_log[0]), 32'h000000A5);

    // fill and overflow
    dut_log.delete();
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h13, 1'b0);
    step(1'b1, 8'h14, 1'b0);
    chk("fill_full",  32'(o_full),  32'd1);
    chk("fill_count", 32'(o_count), 32'd4);
    step(1'b1, 8'h55, 1'b0);
    chk("drop_count", 32'(o_count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      idle(3);
    end
    chk("fill_n", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < dut_log.size()) chk("fill_order", 32'(dut_log[i]), 32'(fill_exp[i]));
    end

    // simultaneous write and pop with two queued and FSM returning to IDLE
    dut_log.delete();
    step(1'b1, 8'h20, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("simul_pre", 32'(o_count), 32'd2);
    step(1'b1, 8'h77, 1'b0);
    chk("simul_cnt", 32'(o_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      idle(2);
      step(1'b0, 8'h00, 1'b1);
    end
    idle(2);
    chk("simul_n", 32'(dut_log.size()), 32'd4);
    if (dut_log.size() == 4) chk("simul_last", 32'(dut_log[3]), 32'h00000077);

    // reset during WAIT with three bytes queued
    dut_log.delete();
    step(1'b1, 8'h30, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    i_reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    i_reset = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    idle(4);
    chk("rst_mid_n", 32'(dut_log.size()), 32'd1);
    chk("rst_mid_empty", 32'(o_empty), 32'd1);

    // wrap-around streaming of 0x00..0x09, done 20 cycles after each start
    dut_log.delete();
    nxt = 0;
    cd = 0;
    guard = 0;
    while ((dut_log.size() < 10 || m_busy) && guard < 600) begin
      wr = (nxt < 10) && (mq.size() < DEPTH);
      dn = (cd == 1);
      step(wr, 8'(nxt), dn);
      if (wr) nxt++;
      if (cd > 0) cd--;
      if (tx_start === 1'b1) cd = 20;
      guard++;
    end
    chk("wrap_timeout", 32'(guard < 600), 32'd1);
    chk("wrap_n", 32'(dut_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < dut_log.size()) chk("wrap_order", 32'(dut_log[i]), 32'(i));
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
